// File: rtl/memory_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_arbiter_if
// Description : Fetch, data and memory-side signals of the memory bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface memory_bus_arbiter_if;
    logic        fetch_request;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;

    logic [31:0] data_address;
    logic [31:0] data_write_data;
    logic [3:0]  data_byte_enable;
    logic        data_read_enable;
    logic        data_write_enable;
    logic        data_ready;
    logic        data_valid;
    logic [31:0] data_read_data;

    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    // Arbiter side
    modport slave (
        input  fetch_request, fetch_address,
        output fetch_ready, fetch_valid, fetch_data,
        input  data_address, data_write_data, data_byte_enable,
        input  data_read_enable, data_write_enable,
        output data_ready, data_valid, data_read_data,
        output mem_address, mem_write_data, mem_byte_enable,
        output mem_read_enable, mem_write_enable,
        input  mem_read_data
    );

    // Requester / memory side
    modport master (
        output fetch_request, fetch_address,
        input  fetch_ready, fetch_valid, fetch_data,
        output data_address, data_write_data, data_byte_enable,
        output data_read_enable, data_write_enable,
        input  data_ready, data_valid, data_read_data,
        input  mem_address, mem_write_data, mem_byte_enable,
        input  mem_read_enable, mem_write_enable,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_arbiter
// Description : Two-requester single-port memory arbiter with fetch anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    memory_bus_arbiter_if.slave bus
);
    localparam int unsigned C_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_DATA  = 2'd2
    } rsp_t;

    rsp_t               r_rsp_owner;
    rsp_t               w_rsp_next;
    logic [C_CNT_W-1:0] r_starve_count;
    logic [C_CNT_W-1:0] w_starve_next;
    logic [31:0]        r_fetch_hold;
    logic [31:0]        r_data_hold;

    logic        w_data_req;
    logic        w_fetch_grant;
    logic        w_data_grant;
    logic [31:0] w_mem_address;
    logic [3:0]  w_mem_byte_enable;
    logic        w_mem_read_enable;
    logic        w_mem_write_enable;
    logic        w_unused_ok;

    // Fetches are always word aligned, so the low address bits are dropped
    assign w_unused_ok = &{1'b0, bus.fetch_address[1:0]};

    always_comb begin
        w_data_req         = bus.data_read_enable | bus.data_write_enable;
        w_fetch_grant      = 1'b0;
        w_data_grant       = 1'b0;
        w_mem_address      = 32'd0;
        w_mem_byte_enable  = 4'd0;
        w_mem_read_enable  = 1'b0;
        w_mem_write_enable = 1'b0;
        w_rsp_next         = RSP_NONE;
        w_starve_next      = '0;

        if (!reset) begin
            w_fetch_grant = bus.fetch_request && (!w_data_req || (r_starve_count == C_LIMIT));
            w_data_grant  = w_data_req && !w_fetch_grant;
        end

        if (w_fetch_grant) begin
            w_mem_address     = {bus.fetch_address[31:2], 2'b00};
            w_mem_byte_enable = 4'b1111;
            w_mem_read_enable = 1'b1;
            w_rsp_next        = RSP_FETCH;
        end else if (w_data_grant) begin
            // A simultaneous read and write is a write; the read is dropped
            w_mem_address      = bus.data_address;
            w_mem_byte_enable  = bus.data_byte_enable;
            w_mem_write_enable = bus.data_write_enable;
            w_mem_read_enable  = !bus.data_write_enable;
            w_rsp_next         = bus.data_write_enable ? RSP_NONE : RSP_DATA;
        end

        if (!reset && bus.fetch_request && !w_fetch_grant) begin
            w_starve_next = (r_starve_count == C_LIMIT) ? r_starve_count : r_starve_count + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rsp_owner    <= RSP_NONE;
            r_starve_count <= '0;
            r_fetch_hold   <= 32'd0;
            r_data_hold    <= 32'd0;
        end else begin
            r_rsp_owner    <= w_rsp_next;
            r_starve_count <= w_starve_next;
            if (r_rsp_owner == RSP_FETCH) begin
                r_fetch_hold <= bus.mem_read_data;
            end
            if (r_rsp_owner == RSP_DATA) begin
                r_data_hold <= bus.mem_read_data;
            end
        end
    end

    assign bus.fetch_ready      = w_fetch_grant;
    assign bus.data_ready       = w_data_grant;
    assign bus.mem_address      = w_mem_address;
    assign bus.mem_byte_enable  = w_mem_byte_enable;
    assign bus.mem_read_enable  = w_mem_read_enable;
    assign bus.mem_write_enable = w_mem_write_enable;
    assign bus.mem_write_data   = bus.data_write_data;

    // Responses are forwarded straight from memory; gating with reset kills in-flight reads
    assign bus.fetch_valid    = !reset && (r_rsp_owner == RSP_FETCH);
    assign bus.data_valid     = !reset && (r_rsp_owner == RSP_DATA);
    assign bus.fetch_data     = reset ? 32'd0 :
                                (r_rsp_owner == RSP_FETCH) ? bus.mem_read_data : r_fetch_hold;
    assign bus.data_read_data = reset ? 32'd0 :
                                (r_rsp_owner == RSP_DATA) ? bus.mem_read_data : r_data_hold;
endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus_arbiter
// Description : Directed and randomized self-checking bench for memory_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_bus_arbiter_if bus();

    memory_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending response owner (0 none, 1 fetch, 2 data), starvation age, held data
    int          m_starve = 0;
    int          m_pend   = 0;
    logic [31:0] m_fhold  = '0;
    logic [31:0] m_dhold  = '0;
    logic        m_dreq, m_fwin, m_dwin;

    initial forever begin
        @(negedge clk);
        m_dreq = bus.data_read_enable | bus.data_write_enable;
        m_fwin = !rst && bus.fetch_request && (!m_dreq || m_starve >= STARVE_LIMIT);
        m_dwin = !rst && m_dreq && !m_fwin;

        chk("fetch_ready", bus.fetch_ready, m_fwin);
        chk("data_ready", bus.data_ready, m_dwin);
        chk("mem_address", bus.mem_address,
            m_fwin ? (bus.fetch_address & 32'hFFFF_FFFC) : m_dwin ? bus.data_address : 32'd0);
        chk("mem_byte_enable", bus.mem_byte_enable,
            m_fwin ? 32'hF : m_dwin ? 32'(bus.data_byte_enable) : 32'd0);
        chk("mem_read_enable", bus.mem_read_enable, m_fwin || (m_dwin && !bus.data_write_enable));
        chk("mem_write_enable", bus.mem_write_enable, m_dwin && bus.data_write_enable);
        chk("mem_write_data", bus.mem_write_data, bus.data_write_data);
        chk("fetch_valid", bus.fetch_valid, !rst && m_pend == 1);
        chk("data_valid", bus.data_valid, !rst && m_pend == 2);
        chk("fetch_data", bus.fetch_data,
            rst ? 32'd0 : (m_pend == 1) ? bus.mem_read_data : m_fhold);
        chk("data_read_data", bus.data_read_data,
            rst ? 32'd0 : (m_pend == 2) ? bus.mem_read_data : m_dhold);

        if (rst) begin
            m_starve = 0;
            m_pend   = 0;
            m_fhold  = '0;
            m_dhold  = '0;
        end else begin
            if (m_pend == 1) m_fhold = bus.mem_read_data;
            if (m_pend == 2) m_dhold = bus.mem_read_data;
            m_pend   = m_fwin ? 1 : (m_dwin && !bus.data_write_enable) ? 2 : 0;
            m_starve = (!bus.fetch_request || m_fwin) ? 0 :
                       (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.fetch_request     = 1'b0;
        bus.fetch_address     = 32'd0;
        bus.data_address      = 32'd0;
        bus.data_write_data   = 32'd0;
        bus.data_byte_enable  = 4'd0;
        bus.data_read_enable  = 1'b0;
        bus.data_write_enable = 1'b0;
    endtask

    int   pulses;
    logic f_rdy, d_rdy;

    initial begin
        set_idle();
        bus.mem_read_data = 32'd0;
        rst = 1'b1;
        bus.fetch_request    = 1'b1;
        bus.data_read_enable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset fetch_ready", bus.fetch_ready, 1'b0);
        chk("reset data_ready", bus.data_ready, 1'b0);
        chk("reset mem_read_enable", bus.mem_read_enable, 1'b0);
        chk("reset fetch_data", bus.fetch_data, 32'd0);

        // Fetch only, granted in the first cycle out of reset
        next_cycle();
        rst = 1'b0;
        set_idle();
        bus.fetch_request = 1'b1;
        bus.fetch_address = 32'h0000_0106;
        #1;
        chk("fetch mem_address", bus.mem_address, 32'h0000_0104);
        chk("fetch mem_byte_enable", bus.mem_byte_enable, 32'hF);
        chk("fetch mem_read_enable", bus.mem_read_enable, 1'b1);
        chk("first fetch_ready", bus.fetch_ready, 1'b1);
        next_cycle();
        bus.fetch_request = 1'b0;
        bus.mem_read_data = 32'h0000_0013;
        #1;
        chk("fetch response valid", bus.fetch_valid, 1'b1);
        chk("fetch response data", bus.fetch_data, 32'h0000_0013);
        chk("fetch response data_valid", bus.data_valid, 1'b0);
        next_cycle();
        bus.mem_read_data = 32'hFFFF_FFFF;
        #1;
        chk("fetch_data hold", bus.fetch_data, 32'h0000_0013);

        // Data write
        bus.data_address      = 32'h1000_0000;
        bus.data_write_data   = 32'hDEAD_BEEF;
        bus.data_byte_enable  = 4'b0011;
        bus.data_write_enable = 1'b1;
        #1;
        chk("write data_ready", bus.data_ready, 1'b1);
        chk("write mem_write_enable", bus.mem_write_enable, 1'b1);
        chk("write mem_byte_enable", bus.mem_byte_enable, 32'h3);
        next_cycle();
        set_idle();
        #1;
        chk("write no data_valid", bus.data_valid, 1'b0);

        // Read and write together behave as a write
        bus.data_address      = 32'h0000_0020;
        bus.data_read_enable  = 1'b1;
        bus.data_write_enable = 1'b1;
        #1;
        chk("rw mem_write_enable", bus.mem_write_enable, 1'b1);
        chk("rw mem_read_enable", bus.mem_read_enable, 1'b0);
        next_cycle();
        set_idle();
        #1;
        chk("rw no data_valid", bus.data_valid, 1'b0);

        // Both requesters held: four data grants, then the fetch
        next_cycle();
        bus.fetch_request    = 1'b1;
        bus.fetch_address    = 32'h0000_0200;
        bus.data_read_enable = 1'b1;
        bus.data_address     = 32'h0000_0300;
        for (int i = 0; i < 10; i++) begin
            bus.mem_read_data = $urandom;
            #1;
            chk("starve fetch_ready", bus.fetch_ready, (i % 5) == 4);
            chk("starve data_ready", bus.data_ready, (i % 5) != 4);
            next_cycle();
        end
        set_idle();

        // Fetch granted, then reset in the following cycle
        next_cycle();
        bus.fetch_request = 1'b1;
        #1;
        chk("pre-reset fetch_ready", bus.fetch_ready, 1'b1);
        next_cycle();
        rst = 1'b1;
        bus.fetch_request = 1'b0;
        bus.mem_read_data = 32'h5555_5555;
        #1;
        chk("reset N+1 fetch_valid", bus.fetch_valid, 1'b0);
        chk("reset N+1 fetch_data", bus.fetch_data, 32'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("reset N+2 fetch_valid", bus.fetch_valid, 1'b0);
        chk("reset N+2 fetch_data", bus.fetch_data, 32'd0);

        // Alternating data read and fetch for 8 cycles
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            set_idle();
            bus.mem_read_data = $urandom;
            if (i < 8) begin
                if (i % 2 == 0) begin
                    bus.data_read_enable = 1'b1;
                    bus.data_address     = 32'(i * 4);
                end else begin
                    bus.fetch_request = 1'b1;
                    bus.fetch_address = 32'h0000_1000 + 32'(i * 4);
                end
            end
            #1;
            pulses += int'(bus.fetch_valid) + int'(bus.data_valid);
        end
        chk("alternating valid pulses", 32'(pulses), 32'd8);

        // Randomized traffic honouring the hold-until-ready rule
        f_rdy = 1'b1;
        d_rdy = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            f_rdy = bus.fetch_ready;
            d_rdy = bus.data_ready;
            next_cycle();
            rst = ($urandom_range(0, 59) == 0);
            bus.mem_read_data = $urandom;
            if (!bus.fetch_request || f_rdy) begin
                bus.fetch_request = ($urandom_range(0, 2) != 0);
                bus.fetch_address = $urandom;
            end
            if (!(bus.data_read_enable || bus.data_write_enable) || d_rdy) begin
                bus.data_read_enable  = ($urandom_range(0, 1) != 0);
                bus.data_write_enable = ($urandom_range(0, 3) == 0);
                bus.data_address      = $urandom;
                bus.data_write_data   = $urandom;
                bus.data_byte_enable  = 4'($urandom);
            end
        end

        next_cycle();
        rst = 1'b0;
        set_idle();
        repeat (2) next_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive cycles a fetch may be denied before it is forced to win.
REQ-002 SHALL have ports: clock  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: fetch_request  in  1  instruction fetch requested.
REQ-005 SHALL have ports: fetch_address  in  32  byte address of the fetch.
REQ-006 SHALL have ports: fetch_ready  out  1  fetch accepted this cycle (combinational).
REQ-007 SHALL have ports: fetch_valid  out  1  fetch_data valid (registered).
REQ-008 SHALL have ports: fetch_data  out  32  returned instruction word.
REQ-009 SHALL have ports: data_address  in  32 | data_write_data  in  32 | data_byte_enable  in  4 | data_read_enable  in  1 | data_write_enable  in  1.
REQ-010 SHALL have ports: data_ready  out  1 (combinational) | data_valid  out  1 (registered) | data_read_data  out  32.
REQ-011 SHALL have ports: mem_address  out  32 | mem_write_data  out  32 | mem_byte_enable  out  4 | mem_read_enable  out  1 | mem_write_enable  out  1 | mem_read_data  in  32 (one-cycle read latency: valid in the cycle after mem_read_enable).

Function
REQ-012 A data request SHALL be data_read_enable | data_write_enable; if both are set, the request SHALL be treated as a write and the read SHALL be ignored.
REQ-013 Requesters SHALL hold all request fields stable until their ready is 1; a transfer SHALL occur in any cycle where request=1 and ready=1.
REQ-014 Arbitration, per cycle:
- data only -> data wins
- fetch only -> fetch wins
- both, starve_count < STARVE_LIMIT -> data wins
- both, starve_count = STARVE_LIMIT -> fetch wins
REQ-015 starve_count SHALL increment (saturating at STARVE_LIMIT) when fetch_request=1 and fetch_ready=0, and SHALL clear to 0 on a fetch grant or when fetch_request=0.
REQ-016 A grant SHALL drive the mem_* outputs combinationally from the winner in the same cycle:
- fetch: mem_address = {fetch_address[31:2],2'b00}, mem_byte_enable = 4'b1111, mem_read_enable = 1, mem_write_enable = 0
- data: mem_address and mem_byte_enable pass through, with the read/write enables from REQ-012
- mem_write_data SHALL always be data_write_data
REQ-017 With no grant, mem_read_enable and mem_write_enable SHALL be 0; mem_address and mem_byte_enable SHALL be 0.
REQ-018 Each granted read SHALL record its owner (FETCH/DATA) in a one-entry response register; in the next cycle the owner's valid SHALL be 1 and its data SHALL equal mem_read_data; the other valid SHALL be 0.
REQ-019 Writes SHALL complete at grant and SHALL produce no data_valid pulse.
REQ-020 Back-to-back issue SHALL be supported: a new grant is allowed in the same cycle a prior read's response returns; throughput is one transfer per cycle.
REQ-021 fetch_data and data_read_data SHALL hold their last returned value when their valid is 0.

Reset
REQ-022 While reset=1: fetch_ready = data_ready = 0, fetch_valid = data_valid = 0, mem enables = 0, starve_count = 0, response register empty, fetch_data = data_read_data = 0.
REQ-023 A read granted in the cycle before reset asserts SHALL NOT produce a valid pulse after reset.
REQ-024 The first grant SHALL be possible in the first cycle with reset=0.

Verification
REQ-025 Fetch only, addr 0x0000_0106, mem returns 0x0000_0013 -> same cycle: mem_address 0x0000_0104, be 1111, rd 1; next cycle: fetch_valid=1, fetch_data=0x13, data_valid=0.
REQ-026 Data write 0x1000_0000, wdata 0xDEAD_BEEF, be 0011 -> data_ready=1, mem_write_enable=1, be 0011; no data_valid afterwards.
REQ-027 Fetch and data read held high continuously, STARVE_LIMIT=4 -> data granted 4 cycles, fetch granted on the 5th, then pattern repeats; each valid routed to the correct owner.
REQ-028 Data read and data write both set -> treated as write: mem_write_enable=1, mem_read_enable=0, no data_valid.
REQ-029 Fetch granted in cycle N, reset=1 in cycle N+1 -> fetch_valid=0 in N+1 and N+2; all outputs at reset values.
REQ-030 Alternating data read and fetch every cycle for 8 cycles -> 8 grants, 8 valid pulses, each one cycle after its grant, with no loss or misrouting.
